// File: rtl/mont_sequencer.sv
// mont_sequencer: control and operand-select stage that feeds the 512-bit
// carry-save Montgomery adder (mpadder).
//
// It latches A, B and M when a start is accepted, then sequences the
// product as follows:
//   1. LOAD: one cycle with zero-gated multiples.
//   2. MULT: N_ITER radix-16 iterations. Each one presents the gated,
//      pre-shifted multiples of B and M to the adder.
//   3. FOLD: the 6-phase carry-propagate fold.
//   4. SUB:  conditional-subtract passes until the adder reports completion.
//   5. FIN:  returns the product with a one-cycle done pulse.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   in_a, in_b, in_m      operands A (multiplier), B (multiplicand), M (odd modulus)
//   busy, done, err       handshake / status (err is sticky until the next start)
//   result                product, held until the next done
//   B0..B3, M0..M3        gated multiples B<<j / M<<j to the adder
//   subtraction           ~M during subtract passes (adder adds carry-in for -M)
//   c_doubleshift         adder shift strobe, high during MULT
//   subtract              high during subtract passes
//   phase                 fold/subtract phase 0..5, or 8 as the adder's idle code
//   cZero..cThree         q-digit bits from the adder, gate M0..M3
//   subtract_finished     adder: the current subtract pass produced the result
//   trueResult            adder: final reduced value
//
// Optional feature (macro MONT_SEQ_CYCLE_COUNT_EN):
//   adds the output cycles[31:0], a saturating count of the operation's
//   cycles. It is cleared on an accepted start and frozen once the
//   sequencer returns to IDLE.

module mont_sequencer #(
  parameter int N_ITER         = 128,
  parameter int MAX_SUB_PASSES = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] in_a,
  input  logic [511:0] in_b,
  input  logic [511:0] in_m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [511:0] result,
  output logic [511:0] B0,
  output logic [512:0] B1,
  output logic [513:0] B2,
  output logic [514:0] B3,
  output logic [511:0] M0,
  output logic [512:0] M1,
  output logic [513:0] M2,
  output logic [514:0] M3,
  output logic [511:0] subtraction,
  output logic         c_doubleshift,
  output logic         subtract,
  output logic [3:0]   phase,
  input  logic         cZero,
  input  logic         cOne,
  input  logic         cTwo,
  input  logic         cThree,
  input  logic         subtract_finished,
  input  logic [511:0] trueResult
`ifdef MONT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]  cycles
`endif
);

  localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int PW = $clog2(MAX_SUB_PASSES + 1);
  localparam logic [2:0] PH_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MULT = 3'd2,
    S_FOLD = 3'd3,
    S_SUB  = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [511:0]    a_sh_q, a_sh_d;
  logic [511:0]    b_q, b_d;
  logic [511:0]    m_q, m_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [2:0]      ph_q, ph_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [PW-1:0]   pass_inc_s;
  logic            err_q, err_d;
  logic [511:0]    result_q, result_d;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      a_sh_q   <= 512'd0;
      b_q      <= 512'd0;
      m_q      <= 512'd0;
      iter_q   <= '0;
      ph_q     <= 3'd0;
      pass_q   <= '0;
      err_q    <= 1'b0;
      result_q <= 512'd0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_q      <= b_d;
      m_q      <= m_d;
      iter_q   <= iter_d;
      ph_q     <= ph_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign pass_inc_s = pass_q + PW'(1);

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_d      = b_q;
    m_d      = m_q;
    iter_d   = iter_q;
    ph_d     = ph_q;
    pass_d   = pass_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          a_sh_d  = in_a;
          b_d     = in_b;
          m_d     = in_m;
          iter_d  = '0;
          ph_d    = 3'd0;
          pass_d  = '0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_MULT;
      end
      S_MULT: begin
        // Consume one radix-16 digit of A per iteration.
        a_sh_d = a_sh_q >> 4;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(N_ITER - 1)) begin
          state_d = S_FOLD;
          ph_d    = 3'd0;
        end else begin
          state_d = S_MULT;
        end
      end
      S_FOLD: begin
        if (ph_q == PH_LAST) begin
          state_d = S_SUB;
          ph_d    = 3'd0;
          pass_d  = '0;
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_SUB: begin
        if (ph_q == PH_LAST) begin
          ph_d = 3'd0;
          // The result is captured on entry to FIN so it is already
          // valid during the done cycle.
          if (subtract_finished) begin
            state_d  = S_FIN;
            result_d = trueResult;
          end else if (pass_inc_s == PW'(MAX_SUB_PASSES)) begin
            state_d  = S_FIN;
            err_d    = 1'b1;
            result_d = trueResult;
            pass_d   = pass_inc_s;
          end else begin
            pass_d = pass_inc_s;
          end
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. M* stay combinational on the adder's q-digit flags.
  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    done          = (state_q == S_FIN);
    err           = err_q;
    result        = result_q;
    B0            = 512'd0;
    B1            = 513'd0;
    B2            = 514'd0;
    B3            = 515'd0;
    M0            = 512'd0;
    M1            = 513'd0;
    M2            = 514'd0;
    M3            = 515'd0;
    subtraction   = 512'd0;
    c_doubleshift = 1'b0;
    subtract      = 1'b0;
    phase         = 4'd8;
    case (state_q)
      S_MULT: begin
        c_doubleshift = 1'b1;
        B0 = a_sh_q[0] ? b_q : 512'd0;
        B1 = a_sh_q[1] ? {b_q, 1'b0} : 513'd0;
        B2 = a_sh_q[2] ? {b_q, 2'b00} : 514'd0;
        B3 = a_sh_q[3] ? {b_q, 3'b000} : 515'd0;
        M0 = cZero  ? m_q : 512'd0;
        M1 = cOne   ? {m_q, 1'b0} : 513'd0;
        M2 = cTwo   ? {m_q, 2'b00} : 514'd0;
        M3 = cThree ? {m_q, 3'b000} : 515'd0;
      end
      S_FOLD: begin
        phase = {1'b0, ph_q};
      end
      S_SUB: begin
        phase       = {1'b0, ph_q};
        subtract    = 1'b1;
        subtraction = ~m_q;
      end
      default: begin
        phase = 4'd8;
      end
    endcase
  end

`ifdef MONT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Cycle counter: cleared on accepted start, counts LOAD through FIN, saturates.
  always_comb begin
    if (state_q == S_IDLE) begin
      cyc_d = start ? 32'd0 : cyc_q;
    end else if (cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mont_sequencer.sv
`timescale 1ns/1ps
module tb_mont_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, start;
  logic [511:0] in_a, in_b, in_m, trueResult;
  logic [3:0]   flags;
  logic         subtract_finished;
  logic         busy, done, err, c_doubleshift, subtract;
  logic [511:0] result, subtraction, B0, M0;
  logic [512:0] B1, M1;
  logic [513:0] B2, M2;
  logic [514:0] B3, M3;
  logic [3:0]   phase;
`ifdef MONT_SEQ_CYCLE_COUNT_EN
  logic [31:0]  cycles;
`endif

  mont_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy), .done(done), .err(err), .result(result),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .M0(M0), .M1(M1), .M2(M2), .M3(M3),
    .subtraction(subtraction), .c_doubleshift(c_doubleshift),
    .subtract(subtract), .phase(phase),
    .cZero(flags[0]), .cOne(flags[1]), .cTwo(flags[2]), .cThree(flags[3]),
    .subtract_finished(subtract_finished), .trueResult(trueResult)
`ifdef MONT_SEQ_CYCLE_COUNT_EN
    , .cycles(cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int fin_pass = 1;
  logic cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [514:0] got, input logic [514:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int passes_for(input int fp);
    return (fp >= 1 && fp <= 4) ? fp : 4;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- behavioural model (timeline from start) ----------------
  // k = cycles since the start cycle: 1 LOAD, 2..129 MULT, 130..135 FOLD,
  // 136.. subtract passes of 6 cycles, done at 136 + 6*passes.
  logic         m_active;
  int           m_k, m_done_k, m_fin;
  logic         m_err, m_run_err;
  logic [511:0] m_res, cap_a, cap_b, cap_m;

  always @(posedge clk) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_err    <= 1'b0;
      m_res    <= 512'd0;
      m_fin    <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active  <= 1'b1;
        m_k       <= 1;
        cap_a     <= in_a;
        cap_b     <= in_b;
        cap_m     <= in_m;
        m_err     <= 1'b0;
        m_fin     <= fin_pass;
        m_done_k  <= 136 + 6 * passes_for(fin_pass);
        m_run_err <= (fin_pass == 0 || fin_pass > 4);
      end
    end else begin
      if (m_k == m_done_k) m_active <= 1'b0;
      else m_k <= m_k + 1;
      if (m_k + 1 == m_done_k) begin
        m_err <= m_run_err;
        m_res <= trueResult;
      end
    end
  end

  // Adder stand-in: reports completion at phase 5 of the configured pass.
  assign subtract_finished = m_active && (m_fin != 0) && (m_k == 135 + 6 * m_fin);

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin : cmp
      logic [514:0] gb [4];
      logic [514:0] gm [4];
      logic [514:0] e;
      logic mult, sub, act;
      int it, ph;
      act  = m_active;
      mult = act && m_k >= 2 && m_k <= 129;
      sub  = act && m_k >= 136 && m_k < m_done_k;
      it   = m_k - 2;
      if (act && m_k >= 130 && m_k <= 135) ph = m_k - 130;
      else if (sub) ph = (m_k - 136) % 6;
      else ph = 8;
      gb[0] = {3'b0, B0}; gb[1] = {2'b0, B1}; gb[2] = {1'b0, B2}; gb[3] = B3;
      gm[0] = {3'b0, M0}; gm[1] = {2'b0, M1}; gm[2] = {1'b0, M2}; gm[3] = M3;
      chk("busy", {514'd0, busy}, {514'd0, act && m_k < m_done_k});
      chk("done", {514'd0, done}, {514'd0, act && m_k == m_done_k});
      chk("err", {514'd0, err}, {514'd0, m_err});
      chk("result", {3'b0, result}, {3'b0, m_res});
      chk("phase", {511'd0, phase}, 515'(ph));
      chk("c_doubleshift", {514'd0, c_doubleshift}, {514'd0, mult});
      chk("subtract", {514'd0, subtract}, {514'd0, sub});
      chk("subtraction", {3'b0, subtraction}, sub ? {3'b0, ~cap_m} : 515'd0);
      for (int j = 0; j < 4; j++) begin
        e = (mult && cap_a[4*it + j]) ? ({3'b0, cap_b} << j) : 515'd0;
        chk($sformatf("B%0d", j), gb[j], e);
        e = (mult && flags[j]) ? ({3'b0, cap_m} << j) : 515'd0;
        chk($sformatf("M%0d", j), gm[j], e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                          input int fp, input logic [3:0] fl);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_m = m; fin_pass = fp; flags = fl; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    bit seen;
    seen = 1'b0; lat = 0; bc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = cyc - t0;
        break;
      end
      if (busy) bc++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout got=no_done exp=done_within_400");
    end
  endtask

  localparam logic [511:0] TR1 = {16{32'hC0DE_1234}};
  localparam logic [511:0] TR2 = {16{32'h0BAD_F00D}};

  initial begin
    int lat, bc, ndone;
    resetn = 1'b0; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    flags = 4'd0; trueResult = '0; fin_pass = 1;
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_phase", {511'd0, phase}, 515'd8);
    chk("rst_result", {3'b0, result}, 515'd0);
    chk("rst_busy_done_err", {512'd0, busy, done, err}, 515'd0);
    chk("rst_B3", B3, 515'd0);
`ifdef MONT_SEQ_CYCLE_COUNT_EN
    chk("rst_cycles", {483'd0, cycles}, 515'd0);
`endif
    @(posedge clk); #1 resetn = 1'b1;

    // 1: minimal operands, finish on pass 1 -> 142 cycle latency
    trueResult = TR1;
    start_op(512'd1, 512'd1, {512{1'b1}}, 1, 4'b0000);
    wait_done(lat, bc);
    chk("t1_latency", 515'(lat), 515'd142);
    chk("t1_busy_cycles", 515'(bc), 515'd141);
    chk("t1_result", {3'b0, result}, {3'b0, TR1});
    chk("t1_err", {514'd0, err}, 515'd0);
`ifdef MONT_SEQ_CYCLE_COUNT_EN
    @(negedge clk);
    chk("t1_cycles", {483'd0, cycles}, 515'd142);
`endif

    // 2: A=5, B=3, M=7 with cOne forced; then flags cleared
    trueResult = TR2;
    start_op(512'd5, 512'd3, 512'd7, 2, 4'b0010);
    @(negedge clk);
    chk("t2_load_B0", {3'b0, B0}, 515'd0);
    chk("t2_load_M1", {2'b0, M1}, 515'd0);
    @(negedge clk);
    chk("t2_it0_B0", {3'b0, B0}, 515'd3);
    chk("t2_it0_B1", {2'b0, B1}, 515'd0);
    chk("t2_it0_B2", {1'b0, B2}, 515'd12);
    chk("t2_it0_B3", B3, 515'd0);
    chk("t2_it0_M1", {2'b0, M1}, 515'd14);
    chk("t2_it0_M0M2M3", {3'b0, M0} | {1'b0, M2} | M3, 515'd0);
    @(posedge clk); #1 flags = 4'b0000;
    @(negedge clk);
    chk("t2_it1_B", {3'b0, B0} | {2'b0, B1} | {1'b0, B2} | B3, 515'd0);
    chk("t2_it1_M", {3'b0, M0} | {2'b0, M1} | {1'b0, M2} | M3, 515'd0);
    wait_done(lat, bc);
    chk("t2_latency", 515'(lat), 515'd148);
    chk("t2_result", {3'b0, result}, {3'b0, TR2});

    // 3: subtract never finishes -> 4 passes, err
    trueResult = TR1;
    start_op(rnd512(), rnd512(), rnd512() | 512'd1, 0, 4'b1011);
    wait_done(lat, bc);
    chk("t3_latency", 515'(lat), 515'd160);
    chk("t3_err_at_done", {514'd0, err}, 515'd1);
    @(negedge clk);
    chk("t3_err_sticky", {514'd0, err}, 515'd1);
`ifdef MONT_SEQ_CYCLE_COUNT_EN
    chk("t3_cycles", {483'd0, cycles}, 515'd160);
`endif

    // 4: err clears on next start; start re-pulsed during MULT is ignored
    trueResult = TR2;
    start_op(rnd512(), rnd512(), rnd512() | 512'd1, 1, 4'b0100);
    @(negedge clk);
    chk("t4_err_cleared", {514'd0, err}, 515'd0);
    repeat (48) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bc);
    chk("t4_latency", 515'(lat), 515'd142);
    chk("t4_result", {3'b0, result}, {3'b0, TR2});

    // 5: reset during iteration 60 aborts; a fresh run completes
    start_op(rnd512(), rnd512(), rnd512() | 512'd1, 1, 4'b0001);
    repeat (61) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("t5_pre_reset_mult", {514'd0, c_doubleshift}, 515'd1);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("t5_phase", {511'd0, phase}, 515'd8);
    chk("t5_busy", {514'd0, busy}, 515'd0);
    chk("t5_cds", {514'd0, c_doubleshift}, 515'd0);
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", 515'(ndone), 515'd0);
    trueResult = TR1;
    start_op(rnd512(), rnd512(), rnd512() | 512'd1, 3, 4'b1111);
    wait_done(lat, bc);
    chk("t5_latency", 515'(lat), 515'd154);
    chk("t5_result", {3'b0, result}, {3'b0, TR1});
    chk("t5_err", {514'd0, err}, 515'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
